// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI mode-0 target that deserializes MOSI words into a
// one-entry RX holding register and serializes TX words onto MISO. All SPI
// pins are oversampled and synchronized into the clk_i domain.
// Optional build macro SPI_SLAVE_LSB_FIRST_EN: both shifters run LSB first.
`timescale 1ns/1ps

module spi_slave_responder #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ss_ni,
  input  logic                  sclk_i,
  input  logic                  sd_i,
  output logic                  sd_o,
  output logic                  sd_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  busy_o,
  output logic                  rx_overrun_o,
  output logic                  tx_underrun_o
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] r_ssSync, r_sclkSync, r_sdSync;
  logic                   r_ssDly, r_sclkDly;
  logic [0:0]             r_state;
  logic [CW-1:0]          r_bitCnt;
  logic                   r_wordDone;
  logic                   r_txFull;
  logic [DATA_WIDTH-1:0]  r_txHold;
  logic [DATA_WIDTH-2:0]  r_txRest;
  logic                   r_sdo, r_sdoe, r_txUnderrun;
  logic [DATA_WIDTH-2:0]  r_rxShift;
  logic [DATA_WIDTH-1:0]  r_rxData;
  logic                   r_rxValid, r_rxOverrun;

  logic                  w_ss, w_sclk, w_sd;
  logic                  w_ssFall, w_ssRise, w_sclkRise, w_sclkFall;
  logic                  w_txAccept, w_load, w_rxStep, w_wordEnd;
  logic [DATA_WIDTH-1:0] w_loadWord, w_rxWord;
  logic                  w_loadFirst, w_nextBit;
  logic [DATA_WIDTH-2:0] w_loadRest, w_restShifted;

  assign w_ss   = r_ssSync[SYNC_STAGES-1];
  assign w_sclk = r_sclkSync[SYNC_STAGES-1];
  assign w_sd   = r_sdSync[SYNC_STAGES-1];

  assign w_ssFall   = r_ssDly & ~w_ss;
  assign w_ssRise   = ~r_ssDly & w_ss;
  assign w_sclkRise = ~r_sclkDly & w_sclk;
  assign w_sclkFall = r_sclkDly & ~w_sclk;

  assign w_txAccept = tx_valid_i & ~r_txFull;
  assign w_loadWord = r_txFull ? r_txHold : FILL_WORD;

  // A load happens on selection and on the first falling sclk after a word
  // completes; an ss rise in the same cycle always wins over sclk activity.
  assign w_load = ((r_state == ST_IDLE) & w_ssFall) |
                  ((r_state == ST_ACTIVE) & ~w_ssRise & w_sclkFall & r_wordDone);

  assign w_rxStep  = (r_state == ST_ACTIVE) & ~w_ssRise & w_sclkRise;
  assign w_wordEnd = w_rxStep & (r_bitCnt == LAST_BIT);

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign w_loadFirst   = w_loadWord[0];
  assign w_loadRest    = w_loadWord[DATA_WIDTH-1:1];
  assign w_nextBit     = r_txRest[0];
  assign w_restShifted = r_txRest >> 1;
  assign w_rxWord      = {w_sd, r_rxShift};
`else
  assign w_loadFirst   = w_loadWord[DATA_WIDTH-1];
  assign w_loadRest    = w_loadWord[DATA_WIDTH-2:0];
  assign w_nextBit     = r_txRest[DATA_WIDTH-2];
  assign w_restShifted = r_txRest << 1;
  assign w_rxWord      = {r_rxShift, w_sd};
`endif

  // Synchronize the SPI pins and keep a delayed copy for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ssSync   <= '1;
      r_sclkSync <= '0;
      r_sdSync   <= '0;
      r_ssDly    <= 1'b1;
      r_sclkDly  <= 1'b0;
    end else begin
      r_ssSync   <= {r_ssSync[SYNC_STAGES-2:0], ss_ni};
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], sclk_i};
      r_sdSync   <= {r_sdSync[SYNC_STAGES-2:0], sd_i};
      r_ssDly    <= w_ss;
      r_sclkDly  <= w_sclk;
    end
  end

  // One-entry TX holding register; a new accept overrides the clear on load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_txFull <= 1'b0;
      r_txHold <= '0;
    end else if (w_txAccept) begin
      r_txFull <= 1'b1;
      r_txHold <= tx_data_i;
    end else if (w_load && r_txFull) begin
      r_txFull <= 1'b0;
    end
  end

  // Transfer FSM: bit counting, TX shifting and registered MISO drive.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_bitCnt     <= '0;
      r_wordDone   <= 1'b0;
      r_txRest     <= '0;
      r_sdo        <= 1'b0;
      r_sdoe       <= 1'b0;
      r_txUnderrun <= 1'b0;
    end else begin
      r_txUnderrun <= 1'b0;
      if (w_load) begin
        r_txRest     <= w_loadRest;
        r_sdo        <= w_loadFirst;
        r_txUnderrun <= ~r_txFull;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_ssFall) begin
            r_state    <= ST_ACTIVE;
            r_bitCnt   <= '0;
            r_wordDone <= 1'b0;
            r_sdoe     <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (w_ssRise) begin
            r_state    <= ST_IDLE;
            r_bitCnt   <= '0;
            r_wordDone <= 1'b0;
            r_sdoe     <= 1'b0;
            r_sdo      <= 1'b0;
          end else if (w_sclkRise) begin
            if (r_bitCnt == LAST_BIT) begin
              r_bitCnt   <= '0;
              r_wordDone <= 1'b1;
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
            end
          end else if (w_sclkFall) begin
            if (r_wordDone) begin
              r_wordDone <= 1'b0;
            end else begin
              r_txRest <= w_restShifted;
              r_sdo    <= w_nextBit;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RX shifting and the one-entry RX holding register with overrun detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rxShift   <= '0;
      r_rxData    <= '0;
      r_rxValid   <= 1'b0;
      r_rxOverrun <= 1'b0;
    end else begin
      r_rxOverrun <= 1'b0;
      if (w_rxStep) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
        r_rxShift <= w_rxWord[DATA_WIDTH-1:1];
`else
        r_rxShift <= w_rxWord[DATA_WIDTH-2:0];
`endif
      end
      if (w_wordEnd && (!r_rxValid || rx_ready_i)) begin
        r_rxData  <= w_rxWord;
        r_rxValid <= 1'b1;
      end else begin
        if (w_wordEnd) begin
          r_rxOverrun <= 1'b1;
        end
        if (r_rxValid && rx_ready_i) begin
          r_rxValid <= 1'b0;
        end
      end
    end
  end

  assign sd_o          = r_sdo;
  assign sd_oe_o       = r_sdoe;
  assign tx_ready_o    = ~r_txFull;
  assign rx_data_o     = r_rxData;
  assign rx_valid_o    = r_rxValid;
  assign busy_o        = (r_state == ST_ACTIVE);
  assign rx_overrun_o  = r_rxOverrun;
  assign tx_underrun_o = r_txUnderrun;

endmodule

// File: tb/tb_spi_slave_responder.sv
// tb_spi_slave_responder: drives spi_slave_responder as an SPI mode-0 master
// at clk/8 and compares MISO, RX words and status pulses against a
// word-level reference model of the responder.
// Honours SPI_SLAVE_LSB_FIRST_EN for the expected bit order.
`timescale 1ns/1ps

module tb_spi_slave_responder;

  localparam int DW = 8;
  localparam logic [DW-1:0] FILL = 8'h00;

  logic          clk = 1'b0;
  logic          rstN;
  logic          ssN, sclk, sdIn;
  logic          sdOut, sdOe;
  logic [DW-1:0] txData;
  logic          txValid, txReady;
  logic [DW-1:0] rxData;
  logic          rxValid, rxReady;
  logic          busy, rxOverrun, txUnderrun;

  int errors = 0;
  int checks = 0;
  int ovCnt = 0;
  int unCnt = 0;
  int oeBad;

  logic [DW-1:0] feedQ[$];
  logic [DW-1:0] mPend[$];
  logic [DW-1:0] recQ[$];
  logic [DW-1:0] expRec[$];
  bit            mosiQ[$];
  bit            misoQ[$];
  bit            mRxValid;
  logic [DW-1:0] mRxData;

  spi_slave_responder #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(2),
    .FILL_WORD  (FILL)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .ss_ni        (ssN),
    .sclk_i       (sclk),
    .sd_i         (sdIn),
    .sd_o         (sdOut),
    .sd_oe_o      (sdOe),
    .tx_data_i    (txData),
    .tx_valid_i   (txValid),
    .tx_ready_o   (txReady),
    .rx_data_o    (rxData),
    .rx_valid_o   (rxValid),
    .rx_ready_i   (rxReady),
    .busy_o       (busy),
    .rx_overrun_o (rxOverrun),
    .tx_underrun_o(txUnderrun)
  );

  // System clock, 10 ns period.
  always #5 clk = ~clk;

  // Monitor pulses and consumed RX words a little after the falling edge.
  always @(negedge clk) begin
    #2;
    if (rstN) begin
      if (rxOverrun === 1'b1) ovCnt++;
      if (txUnderrun === 1'b1) unCnt++;
      if (rxValid === 1'b1 && rxReady === 1'b1) recQ.push_back(rxData);
    end
  end

  // TX producer: offers queued words one at a time while the DUT is ready.
  initial begin
    txValid = 1'b0;
    txData  = '0;
    forever begin
      @(negedge clk);
      if (feedQ.size() > 0 && txReady === 1'b1 && !txValid) begin
        txValid = 1'b1;
        txData  = feedQ.pop_front();
      end else begin
        txValid = 1'b0;
      end
    end
  end

  // Position within the word of the j-th bit on the wire.
  function automatic int bitPos(input int j);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return j;
`else
    return DW - 1 - j;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "/sd_o"}, 32'(sdOut), 32'h0);
    checkOutput({tag, "/sd_oe_o"}, 32'(sdOe), 32'h0);
    checkOutput({tag, "/tx_ready_o"}, 32'(txReady), 32'h1);
    checkOutput({tag, "/rx_data_o"}, 32'(rxData), 32'h0);
    checkOutput({tag, "/rx_valid_o"}, 32'(rxValid), 32'h0);
    checkOutput({tag, "/busy_o"}, 32'(busy), 32'h0);
    checkOutput({tag, "/rx_overrun_o"}, 32'(rxOverrun), 32'h0);
    checkOutput({tag, "/tx_underrun_o"}, 32'(txUnderrun), 32'h0);
  endtask

  task automatic pushTx(input logic [DW-1:0] w);
    feedQ.push_back(w);
    mPend.push_back(w);
  endtask

  task automatic mosiWord(input logic [DW-1:0] w);
    for (int j = 0; j < DW; j++) mosiQ.push_back(w[bitPos(j)]);
  endtask

  task automatic setRxReady(input bit v);
    @(negedge clk);
    rxReady = v;
    if (v && mRxValid) begin
      expRec.push_back(mRxData);
      mRxValid = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  // One ss frame of nbits; trail=1 lets the last falling sclk be seen before
  // ss rises, trail=0 makes them coincide so ss wins.
  task automatic applyStimulus(input string tag, input int nbits, input bit trail);
    logic [DW-1:0] loaded[$];
    logic [DW-1:0] w;
    int nComplete, nLoads, expUnder, expOver, mism;
    repeat (8) @(negedge clk);
    ovCnt = 0;
    unCnt = 0;
    oeBad = 0;
    misoQ.delete();
    ssN = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sdIn = mosiQ[i];
      repeat (4) @(negedge clk);
      misoQ.push_back(sdOut);
      if (sdOe !== 1'b1) oeBad++;
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      if (i == nbits - 1 && !trail) ssN = 1'b1;
    end
    if (trail) begin
      repeat (8) @(negedge clk);
      ssN = 1'b1;
    end
    sdIn = 1'b0;
    repeat (10) @(negedge clk);

    // Reference model: which words get loaded, what the master sees, what
    // the RX side should hold or deliver.
    nComplete = nbits / DW;
    nLoads = 1;
    for (int k = 1; k <= nComplete; k++)
      if (k * DW < nbits || trail) nLoads++;
    expUnder = 0;
    for (int l = 0; l < nLoads; l++) begin
      if (mPend.size() > 0) loaded.push_back(mPend.pop_front());
      else begin
        loaded.push_back(FILL);
        expUnder++;
      end
    end
    mism = 0;
    for (int i = 0; i < nbits; i++) begin
      w = loaded[i / DW];
      if (misoQ[i] !== w[bitPos(i % DW)]) mism++;
    end
    expOver = 0;
    for (int k = 0; k < nComplete; k++) begin
      w = '0;
      for (int j = 0; j < DW; j++) w[bitPos(j)] = mosiQ[k * DW + j];
      if (rxReady) begin
        expRec.push_back(w);
        mRxData = w;
      end else if (!mRxValid) begin
        mRxValid = 1'b1;
        mRxData  = w;
      end else begin
        expOver++;
      end
    end

    checkOutput({tag, "/miso_bit_errors"}, 32'(mism), 32'h0);
    checkOutput({tag, "/sd_oe_low_while_selected"}, 32'(oeBad), 32'h0);
    checkOutput({tag, "/tx_underrun_pulses"}, 32'(unCnt), 32'(expUnder));
    checkOutput({tag, "/rx_overrun_pulses"}, 32'(ovCnt), 32'(expOver));
    checkOutput({tag, "/rx_words_delivered"}, 32'(recQ.size()), 32'(expRec.size()));
    mism = 0;
    for (int i = 0; i < recQ.size() && i < expRec.size(); i++)
      if (recQ[i] !== expRec[i]) mism++;
    checkOutput({tag, "/rx_word_values"}, 32'(mism), 32'h0);
    checkOutput({tag, "/rx_valid_o"}, 32'(rxValid), 32'(mRxValid));
    checkOutput({tag, "/rx_data_o"}, 32'(rxData), 32'(mRxData));
    checkOutput({tag, "/busy_o"}, 32'(busy), 32'h0);
    checkOutput({tag, "/sd_oe_o"}, 32'(sdOe), 32'h0);
    checkOutput({tag, "/sd_o"}, 32'(sdOut), 32'h0);
    checkOutput({tag, "/tx_ready_o"}, 32'(txReady), 32'(mPend.size() == 0));
    recQ.delete();
    expRec.delete();
    mosiQ.delete();
  endtask

  initial begin
    int nw, part, np;
    rstN = 1'b0;
    ssN = 1'b1;
    sclk = 1'b0;
    sdIn = 1'b0;
    rxReady = 1'b0;
    mRxValid = 1'b0;
    mRxData = '0;
    #12;
    checkResetValues("in_reset");
    @(negedge clk);
    rstN = 1'b1;
    repeat (4) @(negedge clk);
    checkResetValues("after_reset");

    $display("[TB] single word");
    pushTx(8'hA5);
    mosiWord(8'h3C);
    applyStimulus("single", 8, 1'b0);

    $display("[TB] back-to-back");
    pushTx(8'h11);
    pushTx(8'h22);
    setRxReady(1'b1);
    mosiWord(8'hF0);
    mosiWord(8'h0F);
    applyStimulus("b2b", 16, 1'b0);

    $display("[TB] underrun and overrun");
    setRxReady(1'b0);
    mosiWord(8'h55);
    mosiWord(8'hAA);
    applyStimulus("under_over", 16, 1'b0);

    $display("[TB] abort mid-word");
    setRxReady(1'b1);
    setRxReady(1'b0);
    for (int i = 0; i < 5; i++) mosiQ.push_back(1'b1);
    applyStimulus("abort", 5, 1'b1);
    mosiWord(8'h81);
    applyStimulus("after_abort", 8, 1'b1);

    $display("[TB] bit order");
    setRxReady(1'b1);
    pushTx(8'h01);
    mosiWord(8'h01);
    applyStimulus("order", 8, 1'b0);

    $display("[TB] randomized frames");
    for (int r = 0; r < 6; r++) begin
      setRxReady(1'($urandom_range(0, 1)));
      nw = $urandom_range(1, 3);
      part = ($urandom_range(0, 1) == 1) ? $urandom_range(1, DW - 1) : 0;
      np = $urandom_range(0, nw + 1);
      for (int p = 0; p < np; p++) pushTx(DW'($urandom));
      for (int k = 0; k < nw; k++) mosiWord(DW'($urandom));
      for (int b = 0; b < part; b++) mosiQ.push_back(1'($urandom_range(0, 1)));
      applyStimulus($sformatf("rand%0d", r), nw * DW + part, 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset mid-transfer");
    setRxReady(1'b1);
    setRxReady(1'b0);
    pushTx(8'hC3);
    mosiWord(8'h7E);
    applyStimulus("pre_reset", 8, 1'b0);
    pushTx(8'hFF);
    pushTx(8'h0F);
    repeat (8) @(negedge clk);
    ssN = 1'b0;
    repeat (8) @(negedge clk);
    sdIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    checkOutput("mid_xfer/busy_o", 32'(busy), 32'h1);
    checkOutput("mid_xfer/sd_o", 32'(sdOut), 32'h1);
    #3;
    rstN = 1'b0;
    #1;
    checkResetValues("reset_mid_xfer");
    @(negedge clk);
    ssN = 1'b1;
    sclk = 1'b0;
    sdIn = 1'b0;
    feedQ.delete();
    mPend.delete();
    recQ.delete();
    expRec.delete();
    mRxValid = 1'b0;
    mRxData = '0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    pushTx(8'h5A);
    mosiWord(8'h81);
    applyStimulus("post_reset", 8, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
SPI target-side responder for the SoC SPI master interface (ss_o/sclk_o/sd_o/sd_i). It deserializes master-out data into parallel words and serializes parallel words back to the master. All SPI pins are oversampled in the system clock domain. It serves as the on-chip peer for loopback tests and as the building block for an external SPI peripheral model.

Parameters:
DATA_WIDTH, 8, bits per SPI word (2..32)
SYNC_STAGES, 2, synchronizer depth on ss_ni, sclk_i and sd_i (>=2)
FILL_WORD, 0, word shifted out when no TX word is pending

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
ss_ni  input  1  slave select from master, active low
sclk_i  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0)
sd_i  input  1  serial data from master (MOSI)
sd_o  output  1  serial data to master (MISO)
sd_oe_o  output  1  MISO output enable, high only while selected
tx_data_i  input  DATA_WIDTH  next word to send
tx_valid_i  input  1  tx_data_i valid
tx_ready_o  output  1  TX holding register empty
rx_data_o  output  DATA_WIDTH  last received word
rx_valid_o  output  1  rx_data_o holds an unread word
rx_ready_i  input  1  consumer accepts rx_data_o
busy_o  output  1  transfer in progress (state ACTIVE)
rx_overrun_o  output  1  one-cycle pulse: received word dropped
tx_underrun_o  output  1  one-cycle pulse: FILL_WORD sent

Behaviour:
- One clock and one asynchronous active-low reset. Every flop resets on rst_ni low. Synchronizers reset to idle levels: ss=1, sclk=0, sd=0.
- Reset values: sd_o=0, sd_oe_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, busy_o=0, rx_overrun_o=0, tx_underrun_o=0.
- Edge detection uses the synchronized signal and a one-flop delayed copy. The master must run sclk_i at or below clk_i/8.
- TX holding register (1 entry):
  - tx_ready_o = !tx_full.
  - A word is accepted when tx_valid_i && tx_ready_o; tx_full sets on the next edge.
  - If a load into the shifter and an accept occur in the same cycle, the load takes the old word and tx_full stays set with the new word.
- RX holding register: rx_valid_o clears on rx_valid_o && rx_ready_i.
- FSM with two states, IDLE and ACTIVE:
  - IDLE -> ACTIVE on a synchronized ss falling edge.
    - Load the TX shifter from the holding register if tx_full, clearing tx_full. Otherwise load FILL_WORD and pulse tx_underrun_o.
    - Clear bit_cnt, assert sd_oe_o, and drive the MSB on sd_o in the same cycle.
  - ACTIVE, sclk rising edge: shift synchronized sd into the RX shifter and increment bit_cnt.
    - When bit_cnt==DATA_WIDTH-1, the word is complete: bit_cnt wraps to 0 and a word_done flag sets.
    - If rx_valid_o is 0, or is being consumed in the same cycle, write rx_data_o and set rx_valid_o.
    - Otherwise keep the old word, drop the new one, and pulse rx_overrun_o.
  - ACTIVE, sclk falling edge with word_done set: load the next TX word with the same rules as entry, clear word_done and drive the new MSB. Without word_done, shift the TX shifter left and drive the next bit.
  - ACTIVE -> IDLE on synchronized ss rising edge, even mid-word:
    - Discard the partial RX word; rx_valid_o and rx_data_o are unaffected.
    - Clear bit_cnt and word_done; deassert sd_oe_o and sd_o.
    - A TX word already loaded into the shifter is lost; the holding register is untouched.
- Simultaneous ss rising edge and sclk edge: ss wins and the sclk edge is ignored.
- busy_o equals (state==ACTIVE).
- sd_o is registered.

Optional Feature:
SPI_SLAVE_LSB_FIRST_EN
- Defined: both shifters operate LSB first. The first bit out after load is tx word bit 0, and received bits fill from bit 0 upward. The received word is presented unreversed.
- Undefined (default): MSB first in both directions.
- Ports, latency and handshakes are identical either way.

Test Plan:
- Reset mid-transfer: assert rst_ni low while ACTIVE -> all outputs return to reset values immediately; next ss fall starts a clean word.
- Single word: preload tx 0xA5, master sends 0x3C with sclk=clk/8 -> master reads 0xA5; rx_data_o=0x3C, rx_valid_o=1 one sample edge plus sync latency after the 8th rising sclk; tx_ready_o back to 1.
- Back-to-back: tx 0x11 then 0x22 supplied while tx_ready_o high, master clocks 16 bits under one ss -> MISO 0x11,0x22; RX 0xF0,0x0F both delivered with rx_ready_i=1; no pulses.
- Underrun/overrun: no TX word, rx_ready_i=0, two words 0x55,0xAA -> MISO 0x00 twice with two tx_underrun_o pulses; rx_data_o stays 0x55; one rx_overrun_o pulse.
- Abort: ss rises after 5 bits of 0xFF -> rx_valid_o unchanged, busy_o=0, sd_oe_o=0; next full word 0x81 received correctly.
- LSB-first build: with SPI_SLAVE_LSB_FIRST_EN, tx 0x01 -> first MISO bit 1; master sends bits 1,0,0,0,0,0,0,0 -> rx_data_o=0x01.
